// File: rtl/beat_sequencer.sv
// Beat sequencer: steps ibeatNum through a song at beat_div+1 cycles per beat with play/pause/stop/loop control.
// All outputs registered (one-cycle latency); no backpressure, play_en low freezes position in PAUSE.
module beat_sequencer #(
    parameter int BEAT_LEN = 64,
    parameter int DIV_W    = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             play_en,
    input  logic             stop,
    input  logic             loop_en,
    input  logic [DIV_W-1:0] beat_div,
    input  logic             is_AM,
    output logic [11:0]      ibeatNum,
    output logic             beat_tick,
    output logic             am_reg,
    output logic             am_change,
    output logic             done,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [11:0] LAST_BEAT = 12'(BEAT_LEN - 1);

    state_t           state_q;
    logic [11:0]      beat_q;
    logic [DIV_W-1:0] div_q;
    logic             tick_q;
    logic             done_q;
    logic             am_q;
    logic             am_chg_q;

    logic             beat_due_d;
    logic [DIV_W-1:0] div_inc_d;

    // ">=" so a beat_div lowered below the running count fires next cycle
    assign beat_due_d = (div_q >= beat_div);
    assign div_inc_d  = div_q + DIV_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            div_q    <= '0;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
            am_q     <= 1'b0;
            am_chg_q <= 1'b0;
        end else begin
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
            am_q     <= is_AM;
            am_chg_q <= is_AM ^ am_q;
            if (stop) begin
                state_q <= IDLE;
                beat_q  <= '0;
                div_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        beat_q <= '0;
                        div_q  <= '0;
                        if (play_en) state_q <= PLAY;
                    end
                    PLAY, PAUSE: begin
                        // Resuming from PAUSE counts in the same cycle, so no beat time is lost
                        if (!play_en) begin
                            state_q <= PAUSE;
                        end else begin
                            state_q <= PLAY;
                            if (!beat_due_d) begin
                                div_q <= div_inc_d;
                            end else begin
                                div_q <= '0;
                                if (beat_q < LAST_BEAT) begin
                                    beat_q <= beat_q + 12'd1;
                                    tick_q <= 1'b1;
                                end else begin
                                    beat_q <= '0;
                                    if (loop_en) begin
                                        tick_q <= 1'b1;
                                    end else begin
                                        state_q <= DONE;
                                        done_q  <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    DONE: begin
                        beat_q <= '0;
                        div_q  <= '0;
                        if (!play_en) state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign ibeatNum  = beat_q;
    assign beat_tick = tick_q;
    assign done      = done_q;
    assign am_reg    = am_q;
    assign am_change = am_chg_q;
    assign state     = state_q;

endmodule
